shift_deserializer: RTL and testbench

- Serial-to-parallel receiver for the 8-bit shift datapath. Collects a frame of 1..8 bits, one bit per accepted beat, into a right-justified byte.
- Direction control `ir` matches the parallel shifter convention:
  - ir=0: shift right, LSB-first stream.
  - ir=1: shift left, MSB-first stream.
- Sits at the receive end of a serial link. Hands the assembled byte downstream over a valid/ready handshake.

---
 rtl/shift_pkg.sv | 14 +
 rtl/frame_align.sv | 10 +
 rtl/shift_deserializer.sv | 75 +++++++
 tb/tb_shift_deserializer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the serial shift datapath.
package shift_pkg;
  localparam int W  = 8;
  localparam int CW = 3;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/frame_align.sv
// Logical right shift with zero fill, used to right-justify LSB-first frames.
module frame_align
  import shift_pkg::*;
(
  input  logic [W-1:0]  din,
  input  logic [CW-1:0] sh,
  output logic [W-1:0]  dout
);
  assign dout = din >> sh;
endmodule

// File: rtl/shift_deserializer.sv
// Collects 1..8 serial bits into a right-justified byte and offers it on a
// valid/ready port; a frame start may overlap the handoff of the previous one.
module shift_deserializer
  import shift_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          ir,
  input  logic [CW-1:0] amt,
  input  logic          sin,
  input  logic          sin_valid,
  output logic          sin_ready,
  output logic [W-1:0]  Y,
  output logic          y_valid,
  input  logic          y_ready,
  output logic          busy
);
  localparam logic [CW-1:0] MAX_AMT = CW'(W - 1);

  state_t        state;
  logic [W-1:0]  sreg;
  logic [CW-1:0] cnt;
  logic          ir_l;
  logic [CW-1:0] amt_l;
  logic          xfer;
  logic [W-1:0]  aligned;

  assign sin_ready = (state != HOLD) || y_ready;
  assign xfer      = sin_valid && sin_ready;
  assign y_valid   = (state == HOLD);
  assign busy      = (state == SHIFT);

  // LSB-first data accumulates at the top of sreg; slide it down to bit 0.
  frame_align u_align (
    .din  (sreg),
    .sh   (MAX_AMT - amt_l),
    .dout (aligned)
  );

  assign Y = (ir_l == DIR_LEFT) ? sreg : aligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      ir_l  <= 1'b0;
      amt_l <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (xfer) begin
            ir_l  <= ir;
            amt_l <= amt;
            sreg  <= (ir == DIR_LEFT) ? {{(W-1){1'b0}}, sin} : {sin, {(W-1){1'b0}}};
            cnt   <= CW'(1);
            state <= (amt == '0) ? HOLD : SHIFT;
          end else if (state == HOLD && y_ready) begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (xfer) begin
            sreg <= (ir_l == DIR_LEFT) ? {sreg[W-2:0], sin} : {sin, sreg[W-1:1]};
            cnt  <= cnt + 1'b1;
            // cnt counts bits already held, so this beat is the last one
            if (cnt == amt_l)
              state <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: vector table plus stall, back-to-back and reset sequences.
module tb_shift_deserializer;
  logic       clk = 1'b0;
  logic       reset;
  logic       ir;
  logic [2:0] amt;
  logic       sin;
  logic       sin_valid;
  logic       sin_ready;
  logic [7:0] Y;
  logic       y_valid;
  logic       y_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_deserializer dut (
    .clk       (clk),
    .reset     (reset),
    .ir        (ir),
    .amt       (amt),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sin_ready (sin_ready),
    .Y         (Y),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .busy      (busy)
  );

  // bits[i] is the i-th serial bit sent; ir2/amt2 are driven after the first bit.
  typedef struct {
    logic       ir;
    logic [2:0] amt;
    logic [7:0] bits;
    logic       ir2;
    logic [2:0] amt2;
    logic [7:0] exp_y;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int n;
    n = int'(v.amt) + 1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) chk({tag, " busy mid"}, {7'd0, busy}, 8'd1);
      chk({tag, " no early valid"}, {7'd0, y_valid}, 8'd0);
      ir        = (i == 0) ? v.ir  : v.ir2;
      amt       = (i == 0) ? v.amt : v.amt2;
      sin       = v.bits[i];
      sin_valid = 1'b1;
      #1 chk({tag, " sin_ready"}, {7'd0, sin_ready}, 8'd1);
    end
    @(negedge clk);
    sin_valid = 1'b0;
    chk({tag, " y_valid"}, {7'd0, y_valid}, 8'd1);
    chk({tag, " Y"}, Y, v.exp_y);
    chk({tag, " busy in hold"}, {7'd0, busy}, 8'd0);
    @(negedge clk);
    chk({tag, " back to idle"}, {7'd0, y_valid}, 8'd0);
  endtask

  initial begin
    vec_t v;
    logic [7:0] seq;

    vecs[0] = '{1'b1, 3'd7, 8'h4D, 1'b1, 3'd7, 8'hB2};
    vecs[1] = '{1'b0, 3'd7, 8'hB2, 1'b0, 3'd7, 8'hB2};
    vecs[2] = '{1'b0, 3'd3, 8'h0D, 1'b0, 3'd3, 8'h0D};
    vecs[3] = '{1'b1, 3'd3, 8'h0D, 1'b1, 3'd3, 8'h0B};
    vecs[4] = '{1'b0, 3'd3, 8'h0D, 1'b1, 3'd7, 8'h0D};
    vecs[5] = '{1'b1, 3'd3, 8'h0D, 1'b0, 3'd0, 8'h0B};
    vecs[6] = '{1'b1, 3'd0, 8'h01, 1'b1, 3'd0, 8'h01};
    vecs[7] = '{1'b0, 3'd0, 8'h01, 1'b0, 3'd0, 8'h01};
    vecs[8] = '{1'b1, 3'd5, 8'h13, 1'b1, 3'd5, 8'h32};
    vecs[9] = '{1'b0, 3'd5, 8'h13, 1'b0, 3'd5, 8'h13};

    reset = 1'b1; ir = 1'b0; amt = 3'd0; sin = 1'b0; sin_valid = 1'b0; y_ready = 1'b1;
    #12;
    chk("reset Y", Y, 8'h00);
    chk("reset y_valid", {7'd0, y_valid}, 8'd0);
    chk("reset busy", {7'd0, busy}, 8'd0);
    chk("reset sin_ready", {7'd0, sin_ready}, 8'd1);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 10; k++) begin
      run_frame(vecs[k], $sformatf("vec%0d", k));
    end

    // HOLD stall: single-bit frame held while downstream is not ready
    @(negedge clk);
    ir = 1'b1; amt = 3'd0; sin = 1'b1; sin_valid = 1'b1; y_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ir = 1'b0; amt = 3'd5; sin = 1'b1; sin_valid = 1'b1;
      #1;
      chk("stall y_valid", {7'd0, y_valid}, 8'd1);
      chk("stall Y", Y, 8'h01);
      chk("stall sin_ready", {7'd0, sin_ready}, 8'd0);
    end
    @(negedge clk);
    chk("stall Y end", Y, 8'h01);
    ir = 1'b1; amt = 3'd2; sin = 1'b0; sin_valid = 1'b1; y_ready = 1'b1;
    #1 chk("handoff sin_ready", {7'd0, sin_ready}, 8'd1);
    @(negedge clk);
    chk("handoff new frame busy", {7'd0, busy}, 8'd1);
    chk("handoff y_valid drop", {7'd0, y_valid}, 8'd0);
    sin = 1'b1;
    @(negedge clk);
    sin = 1'b1;
    @(negedge clk);
    sin_valid = 1'b0;
    chk("handoff frame valid", {7'd0, y_valid}, 8'd1);
    chk("handoff frame Y", Y, 8'h03);
    @(negedge clk);

    // Back-to-back 4-bit MSB-first frames: 1,0,1,1 then 0,1,0,1
    seq = 8'b1010_1101;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 4) begin
        chk("b2b first valid", {7'd0, y_valid}, 8'd1);
        chk("b2b first Y", Y, 8'h0B);
      end else if (k > 4) begin
        chk("b2b gap valid", {7'd0, y_valid}, 8'd0);
      end
      ir = 1'b1; amt = 3'd3; sin = seq[k]; sin_valid = 1'b1; y_ready = 1'b1;
    end
    @(negedge clk);
    sin_valid = 1'b0;
    chk("b2b second valid", {7'd0, y_valid}, 8'd1);
    chk("b2b second Y", Y, 8'h05);
    @(negedge clk);

    // Abort after 5 of 8 bits, then a clean frame
    v = vecs[0];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ir = 1'b1; amt = 3'd7; sin = ~v.bits[k]; sin_valid = 1'b1;
    end
    @(negedge clk);
    sin_valid = 1'b0;
    chk("pre-abort busy", {7'd0, busy}, 8'd1);
    reset = 1'b1;
    #1;
    chk("abort Y", Y, 8'h00);
    chk("abort y_valid", {7'd0, y_valid}, 8'd0);
    chk("abort busy", {7'd0, busy}, 8'd0);
    chk("abort sin_ready", {7'd0, sin_ready}, 8'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post-abort idle", {7'd0, y_valid}, 8'd0);
    run_frame(v, "after abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
